// File: rtl/mlop_pkg.sv
// Shared definitions for the multi-operand accumulate/decompose blocks:
// default widths, divider iteration count and the divider state encoding.
package mlop_pkg;

    localparam int WA_DEF = 16;
    localparam int WX_DEF = 10;
    localparam int N_ITER = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mlopsub_if.sv
// Request/result bundle of the restoring divider: the requester drives
// start/a/x, the divider returns busy/done and the held results.
interface mlopsub_if
    import mlop_pkg::*;
#(
    parameter int WA = WA_DEF,
    parameter int WX = WX_DEF
);
    logic          start;
    logic [WA-1:0] a;
    logic [WX-1:0] x;
    logic          busy;
    logic          done;
    logic [WA-1:0] q;
    logic [WX-1:0] r;
    logic          dz;

    modport master (output start, a, x, input busy, done, q, r, dz);
    modport slave  (input start, a, x, output busy, done, q, r, dz);

endinterface

// File: rtl/mlopsub_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor and subtract if it fits.
module mlopsub_step #(
    parameter int WX = 10
) (
    input  logic [WX:0]   p,
    input  logic          d_msb,
    input  logic [WX-1:0] x,
    output logic [WX:0]   p_next,
    output logic          q_bit
);

    logic [WX:0] t;
    logic [WX:0] diff;

    assign t    = {p[WX-1:0], d_msb};
    assign diff = t - {1'b0, x};
    // p[WX] is always 0 in practice; if it were set, the shifted value
    // would exceed any divisor, so ORing it keeps the compare exact.
    assign q_bit  = p[WX] | (t >= {1'b0, x});
    assign p_next = q_bit ? diff : t;

endmodule

// File: rtl/mlopsub.sv
// Sequential restoring divider: 16-bit dividend by 10-bit divisor, one
// quotient bit per clock, registered outputs held until the next start.
module mlopsub
    import mlop_pkg::*;
#(
    parameter int WA = WA_DEF,
    parameter int WX = WX_DEF
) (
    input  logic       clk,
    input  logic       rst_b,
    mlopsub_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [WA-1:0]    d_reg, d_next;
    logic [WX:0]      p_reg, p_next;
    logic [WX-1:0]    x_reg, x_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WA-1:0]    q_reg, q_next;
    logic [WX-1:0]    r_reg, r_next;
    logic             dz_reg, dz_next;
    logic             busy_reg, done_reg;

    logic [WX:0]      step_p;
    logic             step_q;

    mlopsub_step #(.WX(WX)) u_step (
        .p      (p_reg),
        .d_msb  (d_reg[WA-1]),
        .x      (x_reg),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        p_next     = p_reg;
        x_next     = x_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dz_next    = dz_reg;
        case (state_reg)
            // DONE accepts a new request exactly like IDLE for back-to-back use
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.start) begin
                    if (bus.x != '0) begin
                        d_next     = bus.a;
                        x_next     = bus.x;
                        p_next     = '0;
                        cnt_next   = '0;
                        dz_next    = 1'b0;
                        state_next = RUN;
                    end else begin
                        q_next     = '1;
                        r_next     = '0;
                        dz_next    = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                d_next   = {d_reg[WA-2:0], step_q};
                p_next   = step_p;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(N_ITER - 1)) begin
                    q_next     = {d_reg[WA-2:0], step_q};
                    r_next     = step_p[WX-1:0];
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            p_reg     <= '0;
            x_reg     <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dz_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            p_reg     <= p_next;
            x_reg     <= x_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dz_reg    <= dz_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= (state_next == DONE);
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.q    = q_reg;
    assign bus.r    = r_reg;
    assign bus.dz   = dz_reg;

endmodule

// File: doc/mlopsub.md
# mlopsub

Sequential restoring divider, the decomposition counterpart of the multi-operand accumulator. It takes a 16-bit accumulated value `a` and a 10-bit operand `x` and computes how many whole `x` operands make up `a` (quotient `q`) plus the leftover (remainder `r`). It retires one quotient bit per clock, so a normal division takes a fixed 16 iterations. It sits downstream of the accumulator, for example to compute averages or operand counts from an accumulated sum.

## Interface
- `WA`, 16, dividend / quotient width
- `WX`, 10, divisor / remainder width
- `clk`  in  1  clock, rising edge
- `rst_b`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `a`  in  WA  dividend; captured on the accepted `start` edge
- `x`  in  WX  divisor; captured on the accepted `start` edge
- `busy`  out  1  high while an operation is in progress
- `done`  out  1  one-cycle pulse; results are valid
- `q`  out  WA  quotient; held until the next accepted start
- `r`  out  WX  remainder; held until the next accepted start
- `dz`  out  1  divide-by-zero flag; valid with `done`, held with the results

## Operation
- Reset values: state=IDLE; `busy`=0, `done`=0, `q`=0, `r`=0, `dz`=0; internal registers cleared.
- States: IDLE, RUN, DONE.
- **IDLE**, `start`=1 and `x`≠0:
  - latch dividend shift register D←`a` and divisor X←`x`;
  - clear partial remainder P (WX+1 bits) and iteration counter (5 bits);
  - clear `dz`; go to RUN.
- **IDLE**, `start`=1 and `x`=0:
  - set `q`=16'hFFFF, `r`=0, `dz`=1; go directly to DONE.
- **RUN**, each cycle:
  - T = {P[WX-1:0], D[WA-1]};
  - if T ≥ {1'b0,X}: P←T−X and shift 1 into D's LSB; otherwise P←T and shift 0 into D's LSB;
  - D shifts left by one.
- **RUN exit**: after the 16th iteration, `q`←final D and `r`←P[WX-1:0]; go to DONE.
- **DONE**: `done`=1 for exactly one cycle.
  - `start`=1 in this cycle is accepted, handled exactly as in IDLE.
  - Otherwise go to IDLE.
- Arithmetic rules:
  - all arithmetic is unsigned;
  - P never exceeds WX bits after a subtract, so bit WX is only needed for the compare;
  - q·x + r = a and r < x whenever `dz`=0.
- `busy` = (state==RUN). It is registered, derived from the state.
- `start` while RUN is ignored. Inputs `a` and `x` are don't-care outside accepted start edges.
- `rst_b` asserted mid-RUN: immediate return to the reset values. No `done` is produced for the aborted operation.

## Timing
- Accepted start at edge k, `x`≠0:
  - `busy` high from k to k+16;
  - iterations occur at edges k+1 … k+16;
  - `q`/`r` update at edge k+16;
  - `done` high from k+16 to k+17.
- Accepted start at edge k, `x`=0: `done`, `dz`, `q`, `r` are valid from k to k+1; `busy` stays 0.
- Back-to-back operations: start accepted in the DONE cycle gives a throughput of one division per 17 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (`mlop_pkg`): state enum (IDLE, RUN, DONE), `WA`/`WX` defaults, iteration count constant `N_ITER`=16.
- Sub-module `mlopsub_step`: purely combinational compare/subtract.
  - inputs P, D MSB, X;
  - outputs next P and quotient bit.
- The top level holds the FSM, the counter and the D/P/X/q/r registers.

## Test plan
- `a`=1000, `x`=7, single start pulse → `done` 16 edges after the start edge; `q`=142, `r`=6, `dz`=0; `busy` high for exactly 16 cycles.
- `a`=65535, `x`=1023 → `q`=64, `r`=63. `a`=5, `x`=10 → `q`=0, `r`=5.
- `a`=1234, `x`=0 → `done` one edge after start; `dz`=1, `q`=16'hFFFF, `r`=0, `busy` never high.
- Drive `start` with `a`=9, `x`=2 in the `done` cycle of a 1000/7 operation; hold `start` high throughout the 9/2 RUN phase → exactly one further `done`, with `q`=4, `r`=1.
- Assert `rst_b`=0 at iteration 8 of 1000/7 → all outputs 0 immediately and no `done`. A later 1000/7 still gives 142/6.
- Random unsigned `a`, nonzero `x` (≥1000 operations) → scoreboard checks q·x+r=a and r<x.
